// File: rtl/zx_video_fetch_if.sv
// Screen-RAM port B and colour-stream bundle shared by zx_video_fetch and its RAM/colour stage.
interface zx_video_fetch_if;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        pixel_valid;
  logic [3:0]  colour;

  modport master (output mem_addr, pixel_valid, colour, input mem_data);
  modport slave  (input mem_addr, pixel_valid, colour, output mem_data);
endinterface

// File: rtl/zx_video_fetch.sv
// Spectrum screen fetch: per line reads 32 bitmap/attribute byte pairs, double-buffers them and
// emits 256 {bright,g,r,b} pixels on pix_ce. Define VFETCH_FLASH_EN to enable the FLASH inversion.
module zx_video_fetch #(
  parameter logic [12:0] ATTR_BASE  = 13'h1800,
  parameter int          FLASH_HALF = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [7:0]       line_y,
  output logic             underrun,
  zx_video_fetch_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_BMP, S_ATTR, S_CAPT, S_FULL} state_t;

  localparam logic [8:0] LINE_PIXELS = 9'd256;

  function automatic logic [12:0] bmp_addr(input logic [7:0] y, input logic [4:0] c);
    return {y[7:6], y[2:0], y[5:3], c};
  endfunction

  function automatic logic [12:0] attr_addr(input logic [7:0] y, input logic [4:0] c);
    return ATTR_BASE + {3'b000, y[7:3], c};
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  y_q, y_d;
  logic [4:0]  col_q, col_d;
  logic [12:0] mem_addr_q, mem_addr_d;
  logic [7:0]  sh_bmp_q, sh_bmp_d;
  logic [7:0]  sh_attr_q, sh_attr_d;
  logic        sh_full_q, sh_full_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  cell_attr_q, cell_attr_d;
  logic        cell_flash_q, cell_flash_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  pix_left_q, pix_left_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [3:0]  colour_q, colour_d;
  logic        underrun_q, underrun_d;
  logic        flash_phase;

`ifdef VFETCH_FLASH_EN
  localparam logic [4:0] FLASH_HALF_W = 5'(FLASH_HALF);
  logic [4:0] flash_cnt_q, flash_cnt_d;

  always_comb flash_cnt_d = frame_start ? flash_cnt_q + 5'd1 : flash_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) flash_cnt_q <= '0;
    else       flash_cnt_q <= flash_cnt_d;
  end

  assign flash_phase = (flash_cnt_q >= FLASH_HALF_W);
`else
  localparam int unused_flash_half = FLASH_HALF;
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign flash_phase        = 1'b0;
`endif

  logic       line_go, pix_active, cell_edge, load, starve, ink_sel;
  logic [7:0] cur_bmp, cur_attr;
  logic       cur_flash;

  // NOTE: every variable gets its hold/default value before any branch, so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    y_d           = y_q;
    col_d         = col_q;
    mem_addr_d    = mem_addr_q;
    sh_bmp_d      = sh_bmp_q;
    sh_attr_d     = sh_attr_q;
    sh_full_d     = sh_full_q;
    shift_d       = shift_q;
    cell_attr_d   = cell_attr_q;
    cell_flash_d  = cell_flash_q;
    bit_cnt_d     = bit_cnt_q;
    pix_left_d    = pix_left_q;
    pixel_valid_d = pixel_valid_q;
    colour_d      = colour_q;
    underrun_d    = underrun_q;

    line_go    = line_start && (line_y < 8'd192);
    pix_active = pix_ce && (pix_left_q != 9'd0);
    cell_edge  = pix_active && (bit_cnt_q == 3'd0);
    load       = cell_edge && sh_full_q;
    starve     = cell_edge && !sh_full_q;

    unique case (state_q)
      S_BMP: begin
        mem_addr_d = attr_addr(y_q, col_q);
        state_d    = S_ATTR;
      end
      S_ATTR: begin
        sh_bmp_d = bus.mem_data;
        state_d  = S_CAPT;
      end
      S_CAPT: begin
        sh_attr_d = bus.mem_data;
        sh_full_d = 1'b1;
        state_d   = S_FULL;
      end
      default: ;
    endcase

    // A load frees the shadow; a starved cell abandons its fetch. Either way move to the next column.
    if ((state_q == S_FULL && load) || starve) begin
      if (starve) begin
        underrun_d = 1'b1;
        sh_full_d  = 1'b0;
      end
      if (col_q != 5'd31) begin
        col_d      = col_q + 5'd1;
        mem_addr_d = bmp_addr(y_q, col_q + 5'd1);
        state_d    = S_BMP;
      end else begin
        state_d = S_IDLE;
      end
    end

    cur_bmp   = load ? sh_bmp_q  : (starve ? 8'h00 : shift_q);
    cur_attr  = load ? sh_attr_q : (starve ? 8'h00 : cell_attr_q);
    cur_flash = load ? flash_phase : (starve ? 1'b0 : cell_flash_q);
    ink_sel   = cur_bmp[7] ^ (cur_attr[7] & cur_flash);

    if (pix_active) begin
      if (load) sh_full_d = 1'b0;
      cell_attr_d   = cur_attr;
      cell_flash_d  = cur_flash;
      shift_d       = {cur_bmp[6:0], 1'b0};
      colour_d      = {cur_attr[6], ink_sel ? cur_attr[2:0] : cur_attr[5:3]};
      pixel_valid_d = 1'b1;
      bit_cnt_d     = bit_cnt_q + 3'd1;
      pix_left_d    = pix_left_q - 9'd1;
    end else if (pix_ce) begin
      pixel_valid_d = 1'b0;
      colour_d      = 4'h0;
    end

    // A new line aborts everything in flight, including a pixel on the same clock.
    if (line_go) begin
      state_d      = S_BMP;
      y_d          = line_y;
      col_d        = 5'd0;
      mem_addr_d   = bmp_addr(line_y, 5'd0);
      sh_bmp_d     = 8'h00;
      sh_attr_d    = 8'h00;
      sh_full_d    = 1'b0;
      shift_d      = 8'h00;
      cell_attr_d  = 8'h00;
      cell_flash_d = 1'b0;
      bit_cnt_d    = 3'd0;
      pix_left_d   = LINE_PIXELS;
      underrun_d   = underrun_q;
      if (pix_ce) begin
        pixel_valid_d = 1'b0;
        colour_d      = 4'h0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  // The shadow and shifter bytes are plain registers, so they are cleared with the rest on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      y_q           <= '0;
      col_q         <= '0;
      mem_addr_q    <= '0;
      sh_bmp_q      <= '0;
      sh_attr_q     <= '0;
      sh_full_q     <= 1'b0;
      shift_q       <= '0;
      cell_attr_q   <= '0;
      cell_flash_q  <= 1'b0;
      bit_cnt_q     <= '0;
      pix_left_q    <= '0;
      pixel_valid_q <= 1'b0;
      colour_q      <= '0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      y_q           <= y_d;
      col_q         <= col_d;
      mem_addr_q    <= mem_addr_d;
      sh_bmp_q      <= sh_bmp_d;
      sh_attr_q     <= sh_attr_d;
      sh_full_q     <= sh_full_d;
      shift_q       <= shift_d;
      cell_attr_q   <= cell_attr_d;
      cell_flash_q  <= cell_flash_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_left_q    <= pix_left_d;
      pixel_valid_q <= pixel_valid_d;
      colour_q      <= colour_d;
      underrun_q    <= underrun_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.colour      = colour_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_zx_video_fetch.sv
// Scoreboard bench for zx_video_fetch: a registered screen RAM model, expected pixels queued per line.
module tb_zx_video_fetch;
  logic       clk = 1'b0;
  logic       reset, pix_ce, frame_start, line_start;
  logic [7:0] line_y;
  logic       underrun;

  zx_video_fetch_if bus ();

  zx_video_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .frame_start(frame_start),
    .line_start (line_start),
    .line_y     (line_y),
    .underrun   (underrun),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:6911];
  always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];

  int          total = 0;
  int          bad = 0;
  int          flash_cnt = 0;
  logic [12:0] last_bmp;
  logic [4:0]  sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] bmp_a(input int y, input int c);
    return 13'(((y / 64) << 11) | ((y % 8) << 8) | (((y / 8) % 8) << 5) | c);
  endfunction

  function automatic logic [12:0] attr_a(input int y, input int c);
    return 13'(32'h1800 + (y / 8) * 32 + c);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (bus.mem_addr < 13'h1800) last_bmp = bus.mem_addr;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    flash_cnt++;
  endtask

  task automatic push_line(input int y, input int skip);
    bit         phase;
    logic [7:0] b, a;
    logic       ink;
    phase = 1'b0;
`ifdef VFETCH_FLASH_EN
    phase = ((flash_cnt % 32) >= 16);
`endif
    for (int c = 0; c < 32; c++) begin
      b = ram[bmp_a(y, c)];
      a = ram[attr_a(y, c)];
      for (int k = 7; k >= 0; k--) begin
        ink = b[k] ^ (a[7] & phase);
        if (c < skip)  sb.push_back(5'h10);
        else if (ink)  sb.push_back({1'b1, a[6], a[2:0]});
        else           sb.push_back({1'b1, a[6], a[5:3]});
      end
    end
  endtask

  task automatic pix_check(input int gap);
    logic [4:0] e;
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      check("pixel", {bus.pixel_valid, bus.colour}, e);
    end
    repeat (gap - 1) tick();
  endtask

  // Starts line y (optionally with a colliding pix_ce) and checks npix pixels at the given spacing.
  task automatic run_line(input int y, input int gap, input int npix, input int skip,
                          input bit with_pix, input bit exp_valid);
    sb.delete();
    push_line(y, skip);
    line_y     = 8'(y);
    line_start = 1'b1;
    pix_ce     = with_pix;
    tick();
    line_start = 1'b0;
    pix_ce     = 1'b0;
    check("addr_bmp0", bus.mem_addr, bmp_a(y, 0));
    check("valid_at_start", bus.pixel_valid, with_pix ? 1'b0 : exp_valid);
    if (with_pix) check("colour_at_start", bus.colour, 0);
    tick();
    check("addr_attr0", bus.mem_addr, attr_a(y, 0));
    repeat (gap - 2) tick();
    for (int i = 0; i < npix; i++) pix_check(gap);
  endtask

  task automatic end_line(input int y);
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    check("valid_end", bus.pixel_valid, 0);
    check("sb_drained", sb.size(), 0);
    check("last_bmp_addr", last_bmp, bmp_a(y, 31));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_valid"}, bus.pixel_valid, 0);
    check({tag, "_colour"}, bus.colour, 0);
    check({tag, "_underrun"}, underrun, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pix_ce = 1'b0; frame_start = 1'b0; line_start = 1'b0; line_y = 8'd0;
    for (int i = 0; i < 6912; i++) ram[i] = 8'($urandom);
    ram[0]       = 8'h80;
    ram[13'h1800] = 8'h47;
    for (int c = 0; c < 32; c++) begin
      ram[bmp_a(8, c)]  = 8'hFF;
      ram[attr_a(8, c)] = 8'hB8;
    end
    repeat (3) tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    // Plain line, known first cell, then the interleaved addressing of line 65.
    run_line(0, 4, 256, 0, 0, 0);
    end_line(0);
    run_line(65, 4, 256, 0, 0, 0);
    end_line(65);
    check("addr_y65_col31", bmp_a(65, 31), 13'h091F);
    check("underrun_clean", underrun, 0);

    // FLASH phases: frames 0, 16 and after wrap back to 0.
    run_line(8, 4, 256, 0, 0, 0);
    end_line(8);
    repeat (16) frame_pulse();
    run_line(8, 4, 256, 0, 0, 0);
    end_line(8);
    repeat (16) frame_pulse();
    run_line(8, 4, 256, 0, 0, 0);
    end_line(8);

    // Off-screen line_y is ignored.
    line_y = 8'd200; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("y200_addr", bus.mem_addr, attr_a(8, 31));
    check("y200_valid", bus.pixel_valid, 0);
    repeat (3) tick();
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    check("y200_valid_pix", bus.pixel_valid, 0);
    check("y200_addr_later", bus.mem_addr, attr_a(8, 31));

    // Mid-line restart at pixel 100, then line_start colliding with pix_ce.
    run_line(2, 4, 100, 0, 0, 0);
    run_line(3, 4, 256, 0, 0, 1);
    end_line(3);
    run_line(4, 4, 50, 0, 0, 0);
    run_line(5, 4, 256, 0, 1, 1);
    end_line(5);

    // Pixels every 2 clk starve the first cell; underrun is sticky.
    check("underrun_before", underrun, 0);
    run_line(1, 2, 256, 1, 0, 0);
    end_line(1);
    check("underrun_set", underrun, 1);
    run_line(0, 4, 256, 0, 0, 0);
    end_line(0);
    check("underrun_sticky", underrun, 1);

    // Reset in the middle of a line.
    run_line(6, 4, 40, 0, 0, 0);
    reset = 1'b1;
    tick();
    check_reset_state("midreset");
    reset = 1'b0;
    repeat (4) tick();
    check("post_reset_addr", bus.mem_addr, 0);
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    check("post_reset_valid", bus.pixel_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
